// File: rtl/branch_pkg.sv
// Shared branch definitions: counter encodings, predictor entry layout and the
// conditional-branch opcode used across decode, EX and the predictor.
package branch_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Entry fields are sized for the widest supported address; narrower tags
  // are zero-extended into the tag field.
  localparam int unsigned BP_XLEN = 32;

  typedef struct packed {
    logic               valid;
    logic [BP_XLEN-1:0] tag;
    logic [1:0]         cnt;
    logic [BP_XLEN-1:0] target;
  } bp_entry_t;

endpackage

// File: rtl/sat_cnt2.sv
// Combinational next-state of a 2-bit saturating taken/not-taken counter.
module sat_cnt2
  import branch_pkg::*;
(
  input  logic [1:0] cnt,
  input  logic       taken,
  output logic [1:0] cnt_next
);

  always_comb begin
    cnt_next = cnt;
    if (taken) begin
      if (cnt != ST) cnt_next = cnt + 2'd1;
    end else begin
      if (cnt != SNT) cnt_next = cnt - 2'd1;
    end
  end

endmodule

// File: rtl/branch_pred.sv
// Direct-mapped 2-bit-counter branch predictor with BTB, EX-stage resolution,
// table training and branch/mispredict performance counters.
module branch_pred
  import branch_pkg::*;
#(
  parameter int unsigned IDX_BITS = 6,
  parameter int unsigned XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic [31:0]     br_count,
  output logic [31:0]     mispred_count
);

  localparam int unsigned Entries = 2 ** IDX_BITS;

  bp_entry_t table_q [Entries];

  logic [IDX_BITS-1:0] if_idx, ex_idx;
  bp_entry_t           if_ent, ex_ent, upd_ent;
  logic                if_hit, ex_hit, upd_en, mispredict;
  logic [1:0]          ex_cnt_next;
  logic [BP_XLEN-1:0]  if_tag, ex_tag;
  logic [31:0]         br_count_q, br_count_d, mispred_count_q, mispred_count_d;

  assign if_idx = if_pc[IDX_BITS+1:2];
  assign ex_idx = ex_pc[IDX_BITS+1:2];
  assign if_tag = BP_XLEN'(if_pc[XLEN-1:IDX_BITS+2]);
  assign ex_tag = BP_XLEN'(ex_pc[XLEN-1:IDX_BITS+2]);
  assign if_ent = table_q[if_idx];
  assign ex_ent = table_q[ex_idx];

  // Lookup reads registered state only, so a same-cycle update is not visible.
  always_comb begin
    if_hit      = if_ent.valid && (if_ent.tag == if_tag);
    pred_taken  = if_hit && if_ent.cnt[1];
    pred_target = pred_taken ? XLEN'(if_ent.target) : if_pc + XLEN'(4);
  end

  always_comb begin
    mispredict  = (ex_taken != ex_pred_taken) || (ex_taken && (ex_pred_target != ex_target));
    redirect    = ex_valid && mispredict;
    flush       = redirect;
    redirect_pc = ex_taken ? ex_target : ex_pc + XLEN'(4);
  end

  sat_cnt2 u_sat_cnt2 (
    .cnt      (ex_ent.cnt),
    .taken    (ex_taken),
    .cnt_next (ex_cnt_next)
  );

  always_comb begin
    ex_hit  = ex_ent.valid && (ex_ent.tag == ex_tag);
    upd_ent = ex_ent;
    upd_en  = 1'b0;
    if (ex_valid) begin
      if (ex_hit) begin
        upd_en      = 1'b1;
        upd_ent.cnt = ex_cnt_next;
        if (ex_taken) upd_ent.target = BP_XLEN'(ex_target);
      end else if (ex_taken) begin
        // Allocation on taken only; not-taken misses leave aliases untouched.
        upd_en         = 1'b1;
        upd_ent.valid  = 1'b1;
        upd_ent.tag    = ex_tag;
        upd_ent.cnt    = WT;
        upd_ent.target = BP_XLEN'(ex_target);
      end
    end
  end

  always_comb begin
    br_count_d      = br_count_q + (ex_valid ? 32'd1 : 32'd0);
    mispred_count_d = mispred_count_q + (redirect ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Entries; i++) begin
        table_q[i] <= '{valid: 1'b0, tag: '0, cnt: WNT, target: '0};
      end
      br_count_q      <= '0;
      mispred_count_q <= '0;
    end else begin
      if (upd_en) table_q[ex_idx] <= upd_ent;
      br_count_q      <= br_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  assign br_count      = br_count_q;
  assign mispred_count = mispred_count_q;

endmodule

// File: doc/branch_pred.md
# branch_pred

Dynamic branch predictor for the 5-stage pipeline: a direct-mapped table of 2-bit saturating counters plus a branch target buffer (BTB). The IF stage looks up the fetch PC and receives a predicted next-PC. The EX stage feeds back the resolved outcome of each conditional branch, i.e. the `br_taken` decision and the computed target. The block trains its tables and raises a redirect/flush when a prediction was wrong. It also keeps branch and mispredict performance counters.

## Interface
- `IDX_BITS`, 6: table index width; 2^IDX_BITS entries, indexed by `pc[IDX_BITS+1:2]`.
- `XLEN`, 32: address width.
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — reset, synchronous and active-high.
- `if_pc`  in  XLEN  — PC currently being fetched.
- `pred_taken`  out  1  — prediction for `if_pc`: branch taken.
- `pred_target`  out  XLEN  — predicted next PC; `if_pc+4` when not predicted taken.
- `ex_valid`  in  1  — EX holds a real (non-bubble) conditional branch, opcode 1100011.
- `ex_pc`  in  XLEN  — PC of the branch in EX.
- `ex_taken`  in  1  — resolved branch decision from EX.
- `ex_target`  in  XLEN  — resolved branch target (`pc+imm`).
- `ex_pred_taken`  in  1  — `pred_taken` value carried with this instruction from IF.
- `ex_pred_target`  in  XLEN  — `pred_target` value carried with this instruction from IF.
- `redirect`  out  1  — mispredict; fetch must load `redirect_pc`.
- `redirect_pc`  out  XLEN  — correct next PC.
- `flush`  out  1  — squash IF/ID and ID/EX; equal to `redirect`.
- `br_count`  out  32  — number of resolved branches.
- `mispred_count`  out  32  — number of mispredicts.

## Operation
- Each entry holds: `valid` (1 bit), `tag` (`pc[XLEN-1:IDX_BITS+2]`), `cnt` (2 bits), `target` (XLEN bits).
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- **Lookup (combinational):**
  - `hit = valid && tag == if_pc tag`.
  - `pred_taken = hit && cnt[1]`.
  - `pred_target = pred_taken ? target : if_pc+4`.
- **Resolve (combinational, only when `ex_valid`):**
  - `mispredict = (ex_taken != ex_pred_taken) || (ex_taken && ex_pred_target != ex_target)`.
  - `redirect = flush = ex_valid && mispredict`.
  - `redirect_pc = ex_taken ? ex_target : ex_pc+4`.
  - When `redirect` is low, `redirect_pc` is don't-care but must not be X. Drive `ex_pc+4`.
- **Update (registered, only when `ex_valid`), at the entry indexed by `ex_pc`:**
  - Tag match: `cnt` increments on taken and decrements on not-taken, saturating at 11 and 00.
  - Tag miss or invalid entry, resolved taken: allocate. Set `valid=1`, write the tag, `cnt=10`, `target=ex_target`.
  - Tag miss or invalid entry, resolved not-taken: no allocation; the table is unchanged.
  - On a taken outcome with a tag match, `target` is always rewritten with `ex_target`.
- **Counters:**
  - `br_count` increments on every `ex_valid`.
  - `mispred_count` increments on every `redirect`.
  - Both wrap modulo 2^32.
- **Reset:** all `valid=0`, all `cnt=01`, all targets 0, both perf counters 0.
  - Resulting outputs: `pred_taken=0`, `pred_target=if_pc+4`, `redirect=flush=0`, counts 0.
- **`rst` asserted with `ex_valid` high:** reset wins; no update, no count.
- **Same-index lookup and update in one cycle:** lookup returns the pre-update contents. There is no bypass.
- **Aliasing:** a different PC with the same index overwrites the entry only through the taken-allocation rule above.

## Timing
- Lookup has 0-cycle latency: `pred_*` depend combinationally on `if_pc` and the table state.
- Resolve has 0-cycle latency: `redirect`, `redirect_pc` and `flush` are valid in the same cycle `ex_valid` is high.
- Table and counter updates become visible on the next rising edge.
  - A branch resolved in cycle N affects lookups from cycle N+1 onward.
- Mispredict penalty is 2 cycles: the IF/ID and ID/EX instructions are squashed. The pipeline, not this block, applies the flush.
- `ex_valid` can be asserted on consecutive cycles. The block imposes no stall.

## Structure
- Shared package `branch_pkg` holds:
  - the counter encoding constants `SNT`, `WNT`, `WT`, `ST`;
  - the entry struct `bp_entry_t` (valid, tag, cnt, target);
  - the opcode constant `OP_BRANCH = 7'b1100011`, also used by the decoder and the branch-decision logic.
- Sub-module `sat_cnt2`: combinational 2-bit saturating next-state function (`cnt`, `taken`) -> `cnt_next`. It is reused by a future tournament predictor.
- Table storage is a flop array, not SRAM, so that reset clears it synchronously.

## Test plan
- **Reset state:** apply `rst` for 2 cycles, then `if_pc=0x100` -> `pred_taken=0`, `pred_target=0x104`, `br_count=0`, `mispred_count=0`.
- **Cold taken branch:** `ex_valid=1`, `ex_pc=0x100`, `ex_taken=1`, `ex_target=0x80`, `ex_pred_taken=0` -> `redirect=1`, `redirect_pc=0x80`, `flush=1`. Next cycle, `if_pc=0x100` -> `pred_taken=1`, `pred_target=0x80`, `mispred_count=1`.
- **Saturation:** resolve taken four times at 0x100 -> `cnt=11`. Then resolve not-taken once -> lookup still taken (`cnt=10`). A second not-taken -> lookup not taken, `pred_target=0x104`.
- **Correct prediction:** `ex_pred_taken=1`, `ex_pred_target=0x80`, `ex_taken=1`, `ex_target=0x80` -> `redirect=0`; `br_count` increments and `mispred_count` does not.
- **Target mismatch and aliasing:**
  - Taken with `ex_pred_target=0x80` but `ex_target=0x90` -> `redirect=1`, `redirect_pc=0x90`, and the BTB target is updated to 0x90.
  - `ex_pc=0x100 + 4*2^IDX_BITS` resolved taken -> replaces the entry, so lookup of 0x100 now misses.
- **Simultaneous events:**
  - `if_pc=ex_pc=0x100` during a taken allocation -> same-cycle `pred_taken=0`, next cycle `pred_taken=1`.
  - `rst` high together with `ex_valid` -> no update and counters stay 0.
